bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Four-master round-robin bus arbiter. Sits directly upstream of the master mux and bus_addr_dec.
- The granted master's address is what bus_addr_dec decodes into s0_cs..s7_cs.
- Grants exactly one master at all times (bus parking), rotates fairly on release, and forces rotation after a programmable hold limit when others are waiting.

Parameters:
- NUM_M, 4, number of masters. Fixed at 4; the owner index width is 2.
- MAX_HOLD, 16, maximum consecutive cycles the owner keeps the bus while another master requests. 0 disables forced rotation.
- CNT_W, 8, width of the hold counter. Requires MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active-low
- m0_req  input  1  master 0 bus request, active-high
- m1_req  input  1  master 1 bus request
- m2_req  input  1  master 2 bus request
- m3_req  input  1  master 3 bus request
- m0_grnt  output  1  master 0 grant, active-high, registered
- m1_grnt  output  1  master 1 grant
- m2_grnt  output  1  master 2 grant
- m3_grnt  output  1  master 3 grant
- owner  output  2  index of the current owner (drives master mux select)
- busy  output  1  owner's req is asserted this cycle (combinational from owner and req)
- forced  output  1  one-cycle pulse, registered: the last ownership change was caused by hold-limit expiry

Behaviour:
- Reset (reset=0, async):
  - owner=0, grants=0001, hold_cnt=0, forced=0.
  - Takes effect immediately, including mid-ownership; in-flight ownership is discarded.
- Grants are one-hot decode of owner, never all-zero and never multi-hot.
- Per rising edge, with owner register O and requests R[3:0]:
  - Release: R[O]=0.
    - Next owner = first index with R=1, searching O+1, O+2, O+3 (mod 4).
    - If none, O is kept (parked).
    - hold_cnt <= 0.
  - Hold: R[O]=1, and MAX_HOLD=0, or no other R set, or hold_cnt < MAX_HOLD-1.
    - O kept.
    - hold_cnt increments only while some other R is set; it is cleared when no other R is set.
    - hold_cnt saturates at 2**CNT_W-1.
  - Forced rotation: R[O]=1, MAX_HOLD>0, another R set, and hold_cnt = MAX_HOLD-1.
    - Next owner = first requester after O in round-robin order.
    - hold_cnt <= 0; forced <= 1 for one cycle.
- Grant latency:
  - A request from an idle bus is granted on the edge after it is first seen: 1 cycle.
  - The owner sees grant drop one cycle after deasserting req.
- Wrap-around: the search order wraps 3 -> 0.
- Simultaneous events:
  - The owner releasing while several others request: the closest higher index (mod 4) wins.
  - Requests arriving on the same edge as a release are considered.
- The owner re-asserting req after parking keeps the bus with no extra cycle.
- Masters must hold req until granted.
  - A req dropped before grant is simply not considered.
  - No latching; no stale grants.
- forced is 0 on any non-forced transition or hold cycle.

Test Plan:
- Reset: hold reset=0 with random reqs -> grants=0001, owner=0, forced=0. Release reset with no reqs -> remains 0001 indefinitely.
- Idle grant: owner 0 parked, all req=0, assert m2_req at edge N -> grants=0100, owner=2 after edge N+1. busy=1.
- Round robin: owner=1, assert m0, m2, m3 req, drop m1_req -> owner=2. Drop m2 -> owner=3. Drop m3 -> owner=0 (wrap).
- Forced rotation (MAX_HOLD=4): owner=1 holding, m3_req asserted at cycle 0 -> owner=3 after 4 edges, forced=1 for exactly one cycle. Repeat with MAX_HOLD=0 -> owner stays 1 for 100 cycles.
- Reset mid-operation: owner=3, hold_cnt=2, assert reset=0 between edges -> grants=0001 immediately, no clock required. Deassert -> normal arbitration resumes with hold_cnt=0.
- Randomized 2000 cycles with checker: grants always one-hot, grant matches owner, no requester waits more than 3*MAX_HOLD+3 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with bus parking and a programmable hold limit.
// The owner is always granted; ownership rotates on release or when the hold limit expires.
module bus_arbiter #(
  parameter int NUM_M    = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m3_req,
  output logic       m0_grnt,
  output logic       m1_grnt,
  output logic       m2_grnt,
  output logic       m3_grnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       forced
);

  // Value of hold_cnt on which a waiting master takes the bus on the next edge.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam bit               HOLD_EN   = (MAX_HOLD > 0);

  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] grnt_q, grnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             forced_q, forced_d;
  logic             others;
  logic             owner_req;

  // First requester after the current owner, wrapping 3 -> 0; parks on the owner if none.
  function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [NUM_M-1:0] r);
    logic [1:0] cand;
    logic       found;
    rr_next = cur;
    found   = 1'b0;
    for (int i = 1; i < NUM_M; i++) begin
      cand = cur + 2'(i);
      if (!found && r[cand]) begin
        rr_next = cand;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    req       = {m3_req, m2_req, m1_req, m0_req};
    owner_req = |(req & grnt_q);
    others    = |(req & ~grnt_q);

    owner_d  = owner_q;
    hold_d   = hold_q;
    forced_d = 1'b0;

    if (!owner_req) begin
      owner_d = rr_next(owner_q, req);
      hold_d  = '0;
    end else if (HOLD_EN && others && (hold_q == HOLD_LAST)) begin
      owner_d  = rr_next(owner_q, req);
      hold_d   = '0;
      forced_d = 1'b1;
    end else if (others) begin
      if (hold_q != '1) hold_d = hold_q + CNT_W'(1);
    end else begin
      hold_d = '0;
    end

    grnt_d = 4'b0001 << owner_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= 2'd0;
      grnt_q   <= 4'b0001;
      hold_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      grnt_q   <= grnt_d;
      hold_q   <= hold_d;
      forced_q <= forced_d;
    end
  end

  assign {m3_grnt, m2_grnt, m1_grnt, m0_grnt} = grnt_q;
  assign owner  = owner_q;
  assign busy   = owner_req;
  assign forced = forced_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed vectors push expected post-edge state,
// a monitor pops and compares after every rising edge; a random phase checks grant invariants.
module tb_bus_arbiter;

  typedef struct packed {
    logic       sel;
    logic [1:0] owner;
    logic       forced;
    logic       busy;
  } exp_t;

  localparam int WAIT_LIM = 3 * 4 + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req0;
  logic [3:0] g, g0;
  logic [1:0] own, own0;
  logic       busy, busy0, frc, frc0;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   wt[4];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_M(4), .MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]), .m2_req(req[2]), .m3_req(req[3]),
    .m0_grnt(g[0]), .m1_grnt(g[1]), .m2_grnt(g[2]), .m3_grnt(g[3]),
    .owner(own), .busy(busy), .forced(frc)
  );

  bus_arbiter #(.NUM_M(4), .MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .m0_req(req0[0]), .m1_req(req0[1]), .m2_req(req0[2]), .m3_req(req0[3]),
    .m0_grnt(g0[0]), .m1_grnt(g0[1]), .m2_grnt(g0[2]), .m3_grnt(g0[3]),
    .owner(own0), .busy(busy0), .forced(frc0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] o, input logic f, input logic b);
    exp_t x;
    x.sel = sel; x.owner = o; x.forced = f; x.busy = b;
    sb.push_back(x);
  endtask

  // Drive dut requests for one edge and record the expected state after that edge.
  task automatic step(input logic [3:0] r, input logic [1:0] o, input logic f);
    @(negedge clk);
    req = r;
    push(1'b0, o, f, r[o]);
    @(posedge clk);
  endtask

  task automatic step0(input logic [3:0] r, input logic [1:0] o, input logic f);
    @(negedge clk);
    req0 = r;
    push(1'b1, o, f, r[o]);
    @(posedge clk);
  endtask

  initial begin : monitor
    logic [3:0] oh;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.owner;
        if (!e.sel) begin
          chk("owner", 32'(own), 32'(e.owner));
          chk("grnt", 32'(g), 32'(oh));
          chk("forced", 32'(frc), 32'(e.forced));
          chk("busy", 32'(busy), 32'(e.busy));
        end else begin
          chk("owner0", 32'(own0), 32'(e.owner));
          chk("grnt0", 32'(g0), 32'(oh));
          chk("forced0", 32'(frc0), 32'(e.forced));
          chk("busy0", 32'(busy0), 32'(e.busy));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [3:0] oh;
    reset = 1'b0;
    req   = 4'($urandom);
    req0  = 4'($urandom);
    for (int i = 0; i < 4; i++) wt[i] = 0;

    // Reset held with random requests.
    repeat (5) begin
      @(negedge clk);
      req  = 4'($urandom);
      req0 = 4'($urandom);
      #1;
      chk("rst_grnt", 32'(g), 32'h1);
      chk("rst_owner", 32'(own), 32'h0);
      chk("rst_forced", 32'(frc), 32'h0);
      chk("rst_grnt0", 32'(g0), 32'h1);
    end
    @(negedge clk);
    req   = 4'b0000;
    req0  = 4'b0000;
    reset = 1'b1;

    step(4'b0000, 2'd0, 1'b0);
    step(4'b0000, 2'd0, 1'b0);
    step(4'b0000, 2'd0, 1'b0);

    // Idle grant and round robin with wrap.
    step(4'b0100, 2'd2, 1'b0);
    step(4'b0010, 2'd1, 1'b0);
    step(4'b1101, 2'd2, 1'b0);
    step(4'b1001, 2'd3, 1'b0);
    step(4'b0001, 2'd0, 1'b0);

    // Forced rotation after four edges with m3 waiting, then again back to m1.
    step(4'b0010, 2'd1, 1'b0);
    step(4'b0010, 2'd1, 1'b0);
    step(4'b1010, 2'd1, 1'b0);
    step(4'b1010, 2'd1, 1'b0);
    step(4'b1010, 2'd1, 1'b0);
    step(4'b1010, 2'd3, 1'b1);
    step(4'b1010, 2'd3, 1'b0);
    step(4'b1010, 2'd3, 1'b0);
    step(4'b1010, 2'd3, 1'b0);
    step(4'b1010, 2'd1, 1'b1);
    step(4'b0010, 2'd1, 1'b0);

    // Release with several waiting: closest after the owner wins, search wraps.
    step(4'b1000, 2'd3, 1'b0);
    step(4'b0110, 2'd1, 1'b0);
    // Park, then owner re-asserts with no extra cycle.
    step(4'b0000, 2'd1, 1'b0);
    step(4'b0010, 2'd1, 1'b0);

    // No forced rotation when the hold limit is disabled.
    step0(4'b0010, 2'd1, 1'b0);
    repeat (100) step0(4'b1010, 2'd1, 1'b0);

    // Asynchronous reset mid-ownership with hold count at 2.
    step(4'b1000, 2'd3, 1'b0);
    step(4'b1001, 2'd3, 1'b0);
    step(4'b1001, 2'd3, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_grnt", 32'(g), 32'h1);
    chk("async_owner", 32'(own), 32'h0);
    chk("async_forced", 32'(frc), 32'h0);
    #2;
    reset = 1'b1;
    push(1'b0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    step(4'b1001, 2'd0, 1'b0);
    step(4'b1001, 2'd0, 1'b0);
    step(4'b1001, 2'd3, 1'b1);
    step(4'b1000, 2'd3, 1'b0);

    repeat (2) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    // Random traffic: requesters hold until granted; owners drop at random.
    repeat (2000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && g[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) req[i] = 1'b1;
        end
      end
      @(posedge clk);
      #2;
      oh = 4'b0001 << own;
      chk("onehot", 32'($countones(g)), 32'h1);
      chk("grnt_owner", 32'(g), 32'(oh));
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !g[i]) wt[i]++;
        else wt[i] = 0;
        chk("wait_bound", 32'(wt[i] <= WAIT_LIM), 32'h1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
